// File: rtl/spi_command_engine.sv
// SPI master command engine: accepts one command word per trigger/ready handshake,
// drives the selected active-low slave selects, shifts the word out MSB first on
// SCLK/MOSI in any CPOL/CPHA mode and captures MISO into a response word.
module spi_command_engine #(
    parameter int WORD_BITS = 16,
    parameter int NUM_SS    = 10,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_BITS-1:0] command,
    input  logic [NUM_SS-1:0]    ss,
    input  logic                 trigger,
    input  logic                 CPOL,
    input  logic                 CPHA,
    output logic                 ready,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic [NUM_SS-1:0]    ss_n,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  trail_q, trail_d;   // 1 = current half-period began with a trailing edge
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [WORD_BITS-1:0]  tx_q, tx_d;         // bits still to be presented on mosi
    logic [WORD_BITS-1:0]  rx_q, rx_d;         // MISO capture shift register
    logic                  ready_q, ready_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_SS-1:0]     ss_n_q, ss_n_d;
    logic [WORD_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  div_last, do_lead, do_trail;

    assign div_last = (div_q == DIV_LAST);

    // Next-state and registered-output computation for the transfer sequencer
    always_comb begin
        state_d    = state_q;
        div_d      = div_last ? '0 : div_q + 1'b1;
        bit_d      = bit_q;
        trail_d    = trail_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        ready_d    = ready_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        do_lead    = 1'b0;
        do_trail   = 1'b0;

        case (state_q)
            IDLE: begin
                div_d   = '0;
                sclk_d  = CPOL;
                ss_n_d  = '1;
                ready_d = 1'b1;
                if (trigger && ready_q) begin
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    // CPHA=1 re-presents the MSB on the first leading edge, so keep it queued
                    tx_d    = CPHA ? command : {command[WORD_BITS-2:0], 1'b0};
                    mosi_d  = command[WORD_BITS-1];
                    rx_d    = '0;
                    ss_n_d  = ~ss;
                    ready_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    bit_d   = '0;
                    trail_d = 1'b0;
                    do_lead = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    if (trail_q && (bit_q == BIT_LAST)) begin
                        sclk_d  = cpol_q;
                        state_d = HOLD;
                    end else if (!trail_q) begin
                        trail_d  = 1'b1;
                        do_trail = 1'b1;
                    end else begin
                        trail_d = 1'b0;
                        bit_d   = bit_q + 1'b1;
                        do_lead = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    ss_n_d     = '1;
                    mosi_d     = 1'b0;
                    ready_d    = 1'b1;
                    rx_data_d  = rx_q;
                    rx_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_lead || do_trail) begin
            sclk_d = ~sclk_q;
        end
        if ((do_lead && !cpha_q) || (do_trail && cpha_q)) begin
            rx_d = {rx_q[WORD_BITS-2:0], miso};
        end
        if ((do_lead && cpha_q) || (do_trail && !cpha_q && (bit_q != BIT_LAST))) begin
            mosi_d = tx_q[WORD_BITS-1];
            tx_d   = {tx_q[WORD_BITS-2:0], 1'b0};
        end
    end

    // Control state and registered outputs, cleared by synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            trail_q    <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            ready_q    <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            trail_q    <= trail_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            ready_q    <= ready_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Shift registers are pure data; they are reloaded on every acceptance
    always_ff @(posedge clock) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

    assign ready    = ready_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_command_engine.sv
// Self-checking bench for spi_command_engine: directed transfers with a receive
// scoreboard checked by a monitor whenever rx_valid pulses.
module tb_spi_command_engine;

    localparam int XFER_CYC = 136;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] command;
    logic [9:0]  ss;
    logic        trigger, CPOL, CPHA;
    logic        ready, sclk, mosi, miso;
    logic [9:0]  ss_n;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        loop_en, miso_val;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    assign miso = loop_en ? mosi : miso_val;

    always #5 clock = ~clock;

    spi_command_engine #(.WORD_BITS(16), .NUM_SS(10), .CLK_DIV(4)) dut (
        .clock(clock), .reset(reset), .command(command), .ss(ss), .trigger(trigger),
        .CPOL(CPOL), .CPHA(CPHA), .ready(ready), .sclk(sclk), .mosi(mosi), .miso(miso),
        .ss_n(ss_n), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One complete transfer measured cycle by cycle; inject_at>0 pulses a stray trigger
    task automatic run_xfer(input logic [15:0] cmd, input logic [9:0] ssv, input logic pol,
                            input logic pha, input logic lp, input logic mv,
                            input logic [15:0] exp_rx, input logic chk_mosi, input int inject_at);
        int   low, rises, mbad, ssbad;
        logic prev;
        CPOL = pol; CPHA = pha; loop_en = lp; miso_val = mv; command = cmd; ss = ssv;
        @(negedge clock);
        chk("idle_sclk", {31'd0, sclk}, {31'd0, pol});
        chk("idle_ready", {31'd0, ready}, 32'd1);
        exp_q.push_back(exp_rx);
        trigger = 1'b1;
        @(negedge clock);
        trigger = 1'b0;
        low = 0; rises = 0; mbad = 0; ssbad = 0; prev = sclk;
        while (ready == 1'b0 && low < 1000) begin
            low++;
            if (ss_n !== ~ssv) ssbad++;
            if (sclk && !prev) begin
                if (rises < 16 && mosi !== cmd[15-rises]) mbad++;
                rises++;
            end
            prev = sclk;
            if (low == inject_at) begin
                command = ~cmd; ss = ~ssv; trigger = 1'b1;
            end else if (low == inject_at + 1) begin
                trigger = 1'b0;
            end
            @(negedge clock);
        end
        chk("busy_cycles", low, XFER_CYC);
        chk("sclk_rising_edges", rises, 16);
        chk("ss_n_during_xfer_bad_cycles", ssbad, 0);
        if (chk_mosi) chk("mosi_at_rising_bad_bits", mbad, 0);
        chk("ss_n_after_xfer", {22'd0, ss_n}, 32'h3FF);
        chk("mosi_after_xfer", {31'd0, mosi}, 32'd0);
        command = cmd; ss = ssv;
    endtask

    initial begin
        int t, hi;
        reset = 1'b1; trigger = 1'b0; CPOL = 1'b0; CPHA = 1'b0; command = '0; ss = '0;
        loop_en = 1'b0; miso_val = 1'b0;
        fork
            begin : monitor
                forever begin
                    @(negedge clock);
                    if (!reset && rx_valid) begin
                        if (exp_q.size() == 0) chk("unexpected_rx_valid", 32'd1, 32'd0);
                        else chk("rx_data", {16'd0, rx_data}, {16'd0, exp_q.pop_front()});
                    end
                end
            end
            begin : stimulus
                // Reset state
                repeat (3) @(negedge clock);
                chk("rst_ready", {31'd0, ready}, 32'd1);
                chk("rst_ss_n", {22'd0, ss_n}, 32'h3FF);
                chk("rst_sclk", {31'd0, sclk}, 32'd0);
                chk("rst_mosi", {31'd0, mosi}, 32'd0);
                chk("rst_rx_data", {16'd0, rx_data}, 32'd0);
                chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
                reset = 1'b0;
                repeat (20) @(negedge clock);
                chk("idle_ss_n", {22'd0, ss_n}, 32'h3FF);

                // Mode 0 loopback, mode 3 with MISO high, other modes, multi-hot select
                run_xfer(16'h2600, 10'b10, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2600, 1'b1, -5);
                run_xfer(16'hA5C3, 10'b100, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, -5);
                run_xfer(16'h8001, 10'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8001, 1'b1, -5);
                run_xfer(16'h3C96, 10'b1000000011, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3C96, 1'b0, -5);
                run_xfer(16'h0F0F, 10'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, -5);

                // Stray trigger mid-transfer is ignored, no second transfer follows
                run_xfer(16'h1357, 10'b100000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1357, 1'b1, 20);
                repeat (5) @(negedge clock);
                chk("no_second_xfer_ready", {31'd0, ready}, 32'd1);
                chk("no_second_xfer_ss_n", {22'd0, ss_n}, 32'h3FF);

                // Back-to-back transfers with trigger held high
                CPOL = 1'b0; CPHA = 1'b0; loop_en = 1'b1; command = 16'h5A3C; ss = 10'b0010000000;
                repeat (3) exp_q.push_back(16'h5A3C);
                trigger = 1'b1;
                t = 0;
                while (ss_n[7] == 1'b1 && t < 10) begin t++; @(negedge clock); end
                chk("b2b_start", {31'd0, ss_n[7]}, 32'd0);
                for (int g = 0; g < 2; g++) begin
                    t = 0;
                    while (ss_n[7] == 1'b0 && t < 200) begin t++; @(negedge clock); end
                    chk("b2b_low_cycles", t, XFER_CYC);
                    hi = 0;
                    while (ss_n[7] == 1'b1 && hi < 10) begin hi++; @(negedge clock); end
                    chk("b2b_gap_cycles", hi, 1);
                end
                trigger = 1'b0;
                t = 0;
                while (ready == 1'b0 && t < 200) begin t++; @(negedge clock); end
                chk("b2b_final_ready", {31'd0, ready}, 32'd1);
                repeat (5) @(negedge clock);

                // Reset 50 cycles into a transfer aborts it with no rx_valid
                command = 16'hFFFF; ss = 10'b1; loop_en = 1'b0; miso_val = 1'b1;
                trigger = 1'b1;
                @(negedge clock);
                trigger = 1'b0;
                repeat (49) @(negedge clock);
                chk("abort_busy", {31'd0, ready}, 32'd0);
                reset = 1'b1;
                @(negedge clock);
                chk("abort_ss_n", {22'd0, ss_n}, 32'h3FF);
                chk("abort_sclk", {31'd0, sclk}, 32'd0);
                chk("abort_ready", {31'd0, ready}, 32'd1);
                chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
                reset = 1'b0;
                @(negedge clock);

                // No slave selected: full timing, rx_valid still pulses
                run_xfer(16'h1234, 10'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, -5);
                repeat (5) @(negedge clock);
            end
        join_any
        disable fork;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
